// File: rtl/vc_test_rand_delay_multi_sink_pkg.sv
// rtl/vc_test_rand_delay_multi_sink_pkg.sv - shared types and constants for the random-delay multi-channel sink
package vc_test_rand_delay_multi_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_READY = 2'd2,
        ST_DONE  = 2'd3
    } chan_state_t;

    // Right-shifting Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int ERR_CNT_W = 16;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1
    function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned chan);
        logic [15:0] s;
        s = base ^ 16'(chan);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

endpackage

// File: rtl/vc_test_rand_delay_multi_sink_chan.sv
// rtl/vc_test_rand_delay_multi_sink_chan.sv - one sink channel: FSM, delay LFSR, expected-message memory, comparator
module vc_rand_delay_sink_chan
    import vc_test_rand_delay_multi_sink_pkg::*;
#(
    parameter int          p_msg_sz    = 8,
    parameter int          p_mem_sz    = 16,
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        fixed_mode,
    input  logic                        ld_en,
    input  logic [$clog2(p_mem_sz)-1:0] ld_idx,
    input  logic [p_msg_sz-1:0]         ld_msg,
    input  logic                        ld_last,
    input  logic                        val,
    input  logic [p_msg_sz-1:0]         msg,
    output logic                        rdy,
    output logic                        done,
    output logic                        mismatch,
    output logic [$clog2(p_mem_sz)-1:0] cur_idx
);
    localparam int             IW        = $clog2(p_mem_sz);
    localparam logic [IW:0]    IDX_ONE   = {{IW{1'b0}}, 1'b1};
    localparam logic [7:0]     DELAY_MAX = 8'(p_max_delay);

    chan_state_t         state;
    logic [15:0]         lfsr;
    logic [7:0]          delay_cnt;
    logic [7:0]          draw;
    logic [IW:0]         count;
    logic [IW-1:0]       idx;
    logic [p_msg_sz-1:0] mem [p_mem_sz];
    logic                xfer;

    // Next stall length: either the fixed maximum or the LFSR folded into 0..p_max_delay
    always_comb begin
        draw = fixed_mode ? DELAY_MAX : 8'(lfsr % 16'(p_max_delay + 1));
    end

    assign xfer     = (state == ST_READY) && val;
    assign mismatch = xfer && (msg != mem[idx]);
    assign rdy      = (state == ST_READY);
    assign done     = (state == ST_DONE);
    assign cur_idx  = idx;

    // Expected-message storage is only writable before the channel has been started
    always_ff @(posedge clk) begin
        if (ld_en && state == ST_IDLE) begin
            mem[ld_idx] <= ld_msg;
        end
    end

    // Channel sequencing: load/start, stall countdown, handshake and completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            lfsr      <= p_seed;
            delay_cnt <= '0;
            count     <= '0;
            idx       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_en && ld_last) begin
                        count <= {1'b0, ld_idx} + IDX_ONE;
                    end
                    if (start) begin
                        if (count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_DELAY;
                            delay_cnt <= draw;
                            lfsr      <= lfsr_step(lfsr);
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt == 8'd0) begin
                        state <= ST_READY;
                    end else begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                ST_READY: begin
                    if (val) begin
                        idx <= IW'({1'b0, idx} + IDX_ONE);
                        if (({1'b0, idx} + IDX_ONE) == count) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_DELAY;
                            delay_cnt <= draw;
                            lfsr      <= lfsr_step(lfsr);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/vc_test_rand_delay_multi_sink.sv
// rtl/vc_test_rand_delay_multi_sink.sv - multi-channel random-delay test sink with error aggregation
module vc_test_rand_delay_multi_sink
    import vc_test_rand_delay_multi_sink_pkg::*;
#(
    parameter int          p_nchan     = 2,
    parameter int          p_msg_sz    = 8,
    parameter int          p_mem_sz    = 16,
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [p_nchan-1:0]          val,
    output logic [p_nchan-1:0]          rdy,
    input  logic [p_nchan*p_msg_sz-1:0] msg,
    input  logic                        ld_en,
    input  logic [2:0]                  ld_chan,
    input  logic [$clog2(p_mem_sz)-1:0] ld_idx,
    input  logic [p_msg_sz-1:0]         ld_msg,
    input  logic                        ld_last,
    input  logic                        start,
    input  logic                        fixed_mode,
    output logic                        done,
    output logic                        err,
    output logic [2:0]                  err_chan,
    output logic [$clog2(p_mem_sz)-1:0] err_idx,
    output logic [ERR_CNT_W-1:0]        num_errors
);
    localparam int IW = $clog2(p_mem_sz);

    logic [p_nchan-1:0] chan_done;
    logic [p_nchan-1:0] chan_mis;
    logic [IW-1:0]      chan_idx [p_nchan];
    logic [3:0]         mis_cnt;
    logic [2:0]         first_chan;
    logic [IW-1:0]      first_idx;
    logic [ERR_CNT_W:0] err_sum;

    for (genvar c = 0; c < p_nchan; c++) begin : g_chan
        localparam logic [15:0] CHAN_SEED = chan_seed(p_seed, c);

        vc_rand_delay_sink_chan #(
            .p_msg_sz    (p_msg_sz),
            .p_mem_sz    (p_mem_sz),
            .p_max_delay (p_max_delay),
            .p_seed      (CHAN_SEED)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .fixed_mode (fixed_mode),
            .ld_en      (ld_en && (ld_chan == 3'(c))),
            .ld_idx     (ld_idx),
            .ld_msg     (ld_msg),
            .ld_last    (ld_last),
            .val        (val[c]),
            .msg        (msg[c*p_msg_sz +: p_msg_sz]),
            .rdy        (rdy[c]),
            .done       (chan_done[c]),
            .mismatch   (chan_mis[c]),
            .cur_idx    (chan_idx[c])
        );
    end

    // Count this cycle's mismatches and pick the lowest mismatching channel (scan high to low)
    always_comb begin
        mis_cnt    = '0;
        first_chan = '0;
        first_idx  = '0;
        for (int c = p_nchan - 1; c >= 0; c--) begin
            if (chan_mis[c]) begin
                mis_cnt    = mis_cnt + 4'd1;
                first_chan = 3'(c);
                first_idx  = chan_idx[c];
            end
        end
        err_sum = {1'b0, num_errors} + {{(ERR_CNT_W - 3){1'b0}}, mis_cnt};
    end

    assign done = &chan_done;

    // Sticky error flag, first-error capture and saturating error counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err        <= 1'b0;
            err_chan   <= '0;
            err_idx    <= '0;
            num_errors <= '0;
        end else if (|chan_mis) begin
            err <= 1'b1;
            if (!err) begin
                err_chan <= first_chan;
                err_idx  <= first_idx;
            end
            num_errors <= err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_vc_test_rand_delay_multi_sink.sv
// tb/tb_vc_test_rand_delay_multi_sink.sv - self-checking bench for vc_test_rand_delay_multi_sink
module tb_vc_test_rand_delay_multi_sink;

    localparam int NA = 8, MA = 8192, IWA = 13;
    localparam int NB = 2, MB = 16, IWB = 4, MAXD_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ld_en = 1'b0, ld_last = 1'b0, start = 1'b0, fixed_mode = 1'b0;
    logic [2:0]     ld_chan = '0;
    logic [IWA-1:0] ld_idx = '0;
    logic [7:0]     ld_msg = '0;

    logic [NA-1:0]   val_a = '0, rdy_a;
    logic [NA*8-1:0] msg_a = '0;
    logic            done_a, err_a;
    logic [2:0]      err_chan_a;
    logic [IWA-1:0]  err_idx_a;
    logic [15:0]     num_err_a;

    logic [NB-1:0]   val_b = '0, rdy_b;
    logic [NB*8-1:0] msg_b = '0;
    logic            done_b, err_b;
    logic [2:0]      err_chan_b;
    logic [IWB-1:0]  err_idx_b;
    logic [15:0]     num_err_b;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] expb [NB][MB];
    int         cnt_b [NB];
    bit         m_err, m_rd0;
    int         m_chan, m_idx, m_num;

    always #5 clk = ~clk;

    vc_test_rand_delay_multi_sink #(
        .p_nchan(NA), .p_msg_sz(8), .p_mem_sz(MA), .p_max_delay(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .val(val_a), .rdy(rdy_a), .msg(msg_a),
        .ld_en(ld_en), .ld_chan(ld_chan), .ld_idx(ld_idx), .ld_msg(ld_msg), .ld_last(ld_last),
        .start(start), .fixed_mode(fixed_mode), .done(done_a), .err(err_a),
        .err_chan(err_chan_a), .err_idx(err_idx_a), .num_errors(num_err_a)
    );

    vc_test_rand_delay_multi_sink #(
        .p_nchan(NB), .p_msg_sz(8), .p_mem_sz(MB), .p_max_delay(MAXD_B)
    ) u_dut_b (
        .clk(clk), .reset(reset), .val(val_b), .rdy(rdy_b), .msg(msg_b),
        .ld_en(ld_en), .ld_chan(ld_chan), .ld_idx(ld_idx[IWB-1:0]), .ld_msg(ld_msg), .ld_last(ld_last),
        .start(start), .fixed_mode(fixed_mode), .done(done_b), .err(err_b),
        .err_chan(err_chan_b), .err_idx(err_idx_b), .num_errors(num_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        reset = 1'b0; start = 1'b0; ld_en = 1'b0; val_a = '0; val_b = '0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load(input int c, input int i, input logic [7:0] m, input bit last);
        ld_en = 1'b1; ld_chan = 3'(c); ld_idx = IWA'(i); ld_msg = m; ld_last = last;
        step();
        ld_en = 1'b0; ld_last = 1'b0;
    endtask

    function automatic logic [7:0] dat(input int c, input int i);
        return 8'(c * 37 + i * 13 + 5);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    task automatic load_a_chan(input int c, input int n);
        for (int i = 0; i < n; i++) load(c, i, dat(c, i), i == n - 1);
    endtask

    task automatic load_b(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            expb[c][i] = 8'($urandom);
            load(c, i, expb[c][i], i == n - 1);
        end
        cnt_b[c] = n;
    endtask

    // corrupt: 0 none, 1 index 2 on channels 0/1, 2 every message
    task automatic run_a(input int corrupt, input int budget, output int cycles);
        int pos [NA];
        logic [NA-1:0] rdy_prev;
        bit bad;
        for (int c = 0; c < NA; c++) pos[c] = 0;
        cycles = 0;
        val_a = '1;
        while (!done_a && cycles < budget) begin
            for (int c = 0; c < NA; c++) begin
                bad = (corrupt == 2) || (corrupt == 1 && c < 2 && pos[c] == 2);
                msg_a[c*8 +: 8] = dat(c, pos[c]) ^ (bad ? 8'hFF : 8'h00);
            end
            rdy_prev = rdy_a;
            step();
            cycles++;
            for (int c = 0; c < NA; c++) if (rdy_prev[c]) pos[c]++;
        end
        val_a = '0;
        check("a_done_within_budget", 32'(done_a), 32'd1);
    endtask

    task automatic run_b(input bit fixed, input bit val_always, input int bad_pct,
                         input int stop_xfers, input int budget);
        logic [15:0] lf [NB];
        int wt [NB];
        int ix [NB];
        bit rd [NB];
        bit dn [NB];
        bit vv [NB];
        logic [7:0] mm [NB];
        bit err_before, taken;
        int mis, cyc, x0;
        m_err = 0; m_chan = 0; m_idx = 0; m_num = 0; cyc = 0; x0 = 0;
        for (int c = 0; c < NB; c++) begin
            lf[c] = 16'hACE1 ^ 16'(c);
            if (lf[c] == 16'd0) lf[c] = 16'd1;
            ix[c] = 0; rd[c] = 0; wt[c] = 0; dn[c] = (cnt_b[c] == 0);
            if (!dn[c]) begin
                wt[c] = (fixed ? MAXD_B : int'(lf[c] % 16'(MAXD_B + 1))) + 1;
                lf[c] = lfsr_next(lf[c]);
            end
        end
        fixed_mode = fixed;
        pulse_start();
        forever begin
            check($sformatf("b_rdy_cyc%0d", cyc), 32'(rdy_b), {30'd0, rd[1], rd[0]});
            check($sformatf("b_done_cyc%0d", cyc), 32'(done_b), 32'(dn[0] && dn[1]));
            check($sformatf("b_err_cyc%0d", cyc), 32'(err_b), 32'(m_err));
            check($sformatf("b_nerr_cyc%0d", cyc), 32'(num_err_b), 32'(m_num));
            check($sformatf("b_errchan_cyc%0d", cyc), 32'(err_chan_b), 32'(m_chan));
            check($sformatf("b_erridx_cyc%0d", cyc), 32'(err_idx_b), 32'(m_idx));
            if ((dn[0] && dn[1]) || cyc >= budget) break;
            for (int c = 0; c < NB; c++) begin
                vv[c] = val_always ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (rd[c] && $urandom_range(0, 99) >= bad_pct) mm[c] = expb[c][ix[c]];
                else if (rd[c]) mm[c] = expb[c][ix[c]] ^ 8'(1 << $urandom_range(0, 7));
                else mm[c] = 8'($urandom);
            end
            val_b = {vv[1], vv[0]};
            msg_b = {mm[1], mm[0]};
            step();
            cyc++;
            err_before = m_err; taken = 0; mis = 0;
            for (int c = 0; c < NB; c++) begin
                if (rd[c] && vv[c]) begin
                    if (mm[c] != expb[c][ix[c]]) begin
                        mis++;
                        if (!err_before && !taken) begin
                            m_chan = c; m_idx = ix[c]; taken = 1;
                        end
                        m_err = 1;
                    end
                    ix[c]++;
                    if (c == 0) x0++;
                    rd[c] = 0;
                    if (ix[c] == cnt_b[c]) dn[c] = 1;
                    else begin
                        wt[c] = (fixed ? MAXD_B : int'(lf[c] % 16'(MAXD_B + 1))) + 1;
                        lf[c] = lfsr_next(lf[c]);
                    end
                end else if (!rd[c] && !dn[c]) begin
                    wt[c]--;
                    if (wt[c] == 0) rd[c] = 1;
                end
            end
            m_num = (m_num + mis > 65535) ? 65535 : m_num + mis;
            m_rd0 = rd[0];
            if (stop_xfers >= 0 && x0 >= stop_xfers && rd[0]) break;
        end
        val_b = '0;
        check("b_within_budget", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        int k, cyc;

        // Reset state while reset is held low
        reset = 1'b0;
        step(); step();
        check("rst_rdy_a", 32'(rdy_a), 32'd0);
        check("rst_rdy_b", 32'(rdy_b), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_err_chan", 32'(err_chan_a), 32'd0);
        check("rst_err_idx", 32'(err_idx_a), 32'd0);
        check("rst_num_errors", 32'(num_err_a), 32'd0);

        // Zero stall: ch0 of 4 messages, val always high
        reset_all();
        fixed_mode = 1'b0;
        for (int i = 0; i < 4; i++) load(0, i, 8'h11 + 8'(i), i == 3);
        pulse_start();
        val_a = 8'h01;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_rdy_cyc%0d", i), 32'(rdy_a[0]), 32'(i % 2));
            check($sformatf("t1_done_cyc%0d", i), 32'(done_a), 32'd0);
            if (rdy_a[0]) begin
                msg_a[7:0] = 8'h11 + 8'(k);
                k++;
            end
            step();
        end
        val_a = '0;
        check("t1_transfers", 32'(k), 32'd4);
        check("t1_done", 32'(done_a), 32'd1);
        check("t1_num_errors", 32'(num_err_a), 32'd0);
        check("t1_err", 32'(err_a), 32'd0);

        // Simultaneous mismatch at index 2 on ch0 and ch1
        reset_all();
        load_a_chan(0, 4);
        load_a_chan(1, 4);
        pulse_start();
        run_a(1, 100, cyc);
        check("t2_cycles", 32'(cyc), 32'd8);
        check("t2_err", 32'(err_a), 32'd1);
        check("t2_err_chan", 32'(err_chan_a), 32'd0);
        check("t2_err_idx", 32'(err_idx_a), 32'd2);
        check("t2_num_errors", 32'(num_err_a), 32'd2);

        // Empty channels finish at start; done waits for ch0's third transfer
        reset_all();
        load_a_chan(0, 3);
        pulse_start();
        check("t3_done_after_start", 32'(done_a), 32'd0);
        run_a(0, 100, cyc);
        check("t3_cycles", 32'(cyc), 32'd6);
        check("t3_done", 32'(done_a), 32'd1);
        check("t3_num_errors", 32'(num_err_a), 32'd0);

        // Random delays with every message wrong, reset abandoned after ch0's second transfer
        reset_all();
        load_b(0, 4);
        load_b(1, 4);
        run_b(1'b0, 1'b0, 100, 2, 200);
        check("t4_rdy_before_reset", 32'(rdy_b[0]), 32'(m_rd0));
        check("t4_err_before_reset", 32'(err_b), 32'(m_err));
        reset = 1'b0;
        #1;
        check("t4_rdy_in_reset", 32'(rdy_b), 32'd0);
        check("t4_done_in_reset", 32'(done_b), 32'd0);
        check("t4_err_in_reset", 32'(err_b), 32'd0);
        check("t4_err_chan_in_reset", 32'(err_chan_b), 32'd0);
        check("t4_err_idx_in_reset", 32'(err_idx_b), 32'd0);
        check("t4_num_in_reset", 32'(num_err_b), 32'd0);
        step();
        reset = 1'b1;
        step();
        load_b(0, 4);
        load_b(1, 4);
        run_b(1'b0, 1'b0, 15, -1, 300);

        // Fixed mode: every stall is p_max_delay, ch1 empty
        reset_all();
        cnt_b[1] = 0;
        load_b(0, 2);
        run_b(1'b1, 1'b1, 0, -1, 100);
        fixed_mode = 1'b0;

        // Longer random run, full-depth ch0 and uneven ch1
        reset_all();
        load_b(0, 16);
        load_b(1, 11);
        run_b(1'b0, 1'b0, 20, -1, 600);

        // Saturation: 8 channels x 8192 wrong messages = 65536 mismatches
        reset_all();
        for (int c = 0; c < NA; c++) load_a_chan(c, MA);
        pulse_start();
        run_a(2, 20000, cyc);
        check("t7_cycles", 32'(cyc), 32'd16384);
        check("t7_num_errors_saturated", 32'(num_err_a), 32'h0000FFFF);
        check("t7_err", 32'(err_a), 32'd1);
        check("t7_err_chan", 32'(err_chan_a), 32'd0);
        check("t7_err_idx", 32'(err_idx_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_test_rand_delay_multi_sink.md
VC_TEST_RAND_DELAY_MULTI_SINK -- requirements
Module: vc_test_rand_delay_multi_sink

Interface
REQ-001 SHALL have parameter p_nchan, default 2: number of independent sink channels (1..8).
REQ-002 SHALL have parameter p_msg_sz, default 8: message width in bits.
REQ-003 SHALL have parameter p_mem_sz, default 16: expected-message entries per channel (power of two).
REQ-004 SHALL have parameter p_max_delay, default 0: maximum inter-message stall in cycles (0..255).
REQ-005 SHALL have parameter p_seed, default 16'hACE1: LFSR base seed; channel c uses p_seed ^ c, forced to 1 if the result is 0.
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports val  input  p_nchan, rdy  output  p_nchan, msg  input  p_nchan*p_msg_sz: per-channel handshake; channel c uses bit c and msg slice c.
REQ-009 SHALL have ports ld_en  input  1, ld_chan  input  3, ld_idx  input  log2(p_mem_sz), ld_msg  input  p_msg_sz, ld_last  input  1: expected-message load port.
REQ-010 SHALL have ports start  input  1 (pulse, begins all channels) and fixed_mode  input  1 (1 = every stall equals p_max_delay).
REQ-011 SHALL have outputs done 1, err 1, err_chan 3, err_idx log2(p_mem_sz), num_errors 16.

Function
REQ-012 Each channel SHALL run FSM IDLE -> DELAY -> READY -> (DELAY | DONE); rdy[c] SHALL be 1 only in READY.
REQ-013 In IDLE, ld_en with ld_chan==c SHALL write ld_msg to mem[c][ld_idx]; if ld_last=1, count[c] SHALL become ld_idx+1; ld_en SHALL be ignored for channels not in IDLE and for ld_chan>=p_nchan.
REQ-014 start SHALL move every IDLE channel with count 0 to DONE and every other IDLE channel to DELAY with a freshly drawn delay; start outside IDLE SHALL be ignored.
REQ-015 Delay draw: random mode SHALL use the 16-bit Galois LFSR (taps 16,14,13,11) value mod (p_max_delay+1); fixed mode SHALL use p_max_delay; the LFSR SHALL advance once per draw.
REQ-016 DELAY SHALL decrement its counter each cycle and enter READY when the counter is 0; a draw of 0 SHALL enter READY the cycle after the draw (DELAY lasts exactly 1 cycle).
REQ-017 A transfer SHALL occur when val[c] and rdy[c] are both 1; msg is compared to mem[c][idx[c]], then idx[c] increments.
REQ-018 After a transfer, if idx[c]+1 == count[c] the channel SHALL enter DONE, else DELAY with a new draw.
REQ-019 On mismatch, err SHALL set (sticky); on the first mismatch only, err_chan/err_idx SHALL capture the channel and index; simultaneous first mismatches SHALL capture the lowest channel.
REQ-020 num_errors SHALL add the number of mismatching channels in that cycle, saturating at 16'hFFFF.
REQ-021 done SHALL be 1 exactly when all channels are in DONE; DONE SHALL hold until reset.
REQ-022 msg and val in non-READY states SHALL be ignored (no compare, no count change).

Reset
REQ-023 Asserting reset (low) SHALL immediately force: all FSMs IDLE, rdy=0, done=0, err=0, err_chan=0, err_idx=0, num_errors=0, idx=0, count=0, LFSRs to seed; mem contents need not be reset.
REQ-024 Reset mid-run SHALL abandon all progress; a new load and start are required.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, LFSR tap constant and the 16-bit error-counter width.
REQ-026 One per-channel sub-module vc_rand_delay_sink_chan (FSM, LFSR, memory, comparator) SHALL be instantiated p_nchan times; the top SHALL hold only error aggregation and done logic.

Verification
REQ-027 p_max_delay=0, ch0 loaded 4 msgs 0x11..0x14, val held 1 with correct data -> rdy pattern 0,1,0,1,... transfers in 4 of 8 cycles post-start, done=1, num_errors=0.
REQ-028 fixed_mode=1, p_max_delay=3, ch0 of 2 msgs -> exactly 4 cycles rdy=0 before each rdy=1.
REQ-029 2 channels, index 2 wrong on both in the same cycle -> err=1, err_chan=0, err_idx=2, num_errors=2.
REQ-030 count 0 on ch1, ch0 loaded 3 msgs -> ch1 DONE at start, done only after ch0's 3rd transfer.
REQ-031 reset pulsed low mid-run after 2 transfers -> all outputs 0 same cycle; reload+start completes with identical rdy timing from seed.
REQ-032 num_errors preset near saturation via 65536 mismatches -> holds 16'hFFFF, no wrap.
